fft_output_reader: RTL and testbench

Output-side reader for the FFT pipeline. It captures the final inter-stage's scattered write stream (data plus write pointer) into a ping-pong frame buffer. Each completed frame is then streamed out in natural index order 0..N-1 over a valid/ready handshake. It decouples the fixed-rate FFT core from a back-pressured consumer (UART packer, DMA, magnitude stage).

---
 rtl/fft_pkg.sv | 16 +
 rtl/fft_frame_bank.sv | 35 +++
 rtl/fft_output_reader.sv | 124 ++++++++++++
 tb/tb_fft_output_reader.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types for the FFT output side: complex sample layout and reader states.
package fft_pkg;

  localparam int BIT_WIDTH = 24;

  typedef struct packed {
    logic signed [BIT_WIDTH-1:0] re;
    logic signed [BIT_WIDTH-1:0] im;
  } cplx_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } rd_state_t;

endpackage

// File: rtl/fft_frame_bank.sv
// One N-entry frame bank: synchronous write, combinational read, and a full flag
// that marks a completed frame waiting to be streamed out.
module fft_frame_bank #(
  parameter int bit_width = 24,
  parameter int N         = 16,
  parameter int SIZE      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [SIZE-1:0]        waddr,
  input  logic [2*bit_width-1:0] wdata,
  input  logic [SIZE-1:0]        raddr,
  output logic [2*bit_width-1:0] rdata,
  input  logic                   set_full,
  input  logic                   clr_full,
  output logic                   full
);

  // Contents survive reset; only the full flag marks valid frames.
  logic [2*bit_width-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

  always_ff @(posedge clk) begin
    if (rst)           full <= 1'b0;
    else if (set_full) full <= 1'b1;
    else if (clr_full) full <= 1'b0;
  end

endmodule

// File: rtl/fft_output_reader.sv
// Captures the FFT final-stage scattered writes into a ping-pong buffer and streams
// each completed frame out in natural bin order over valid/ready.
module fft_output_reader
  import fft_pkg::*;
#(
  parameter int bit_width = 24,
  parameter int N         = 16,
  parameter int SIZE      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid_i,
  input  logic signed [bit_width-1:0] Re_i,
  input  logic signed [bit_width-1:0] Im_i,
  input  logic [SIZE-1:0]             wr_ptr_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic signed [bit_width-1:0] Re_o,
  output logic signed [bit_width-1:0] Im_o,
  output logic [SIZE-1:0]             idx_o,
  output logic                        last_o,
  output logic                        frame_done_o,
  output logic                        overflow_o
);

  // Handshake: a beat transfers on a rising edge where valid_o && ready_i; while
  // valid_o is high and ready_i low, all output fields hold their values.
  localparam logic [SIZE:0] LAST_CNT  = (SIZE+1)'(N-1);
  localparam logic [SIZE:0] FRAME_CNT = (SIZE+1)'(N);

  rd_state_t              state;
  logic                   wbank, rbank;
  logic [SIZE:0]          wcnt, rcnt;
  logic [1:0]             full, we, set_full, clr_full;
  logic [2*bit_width-1:0] rdata [2];
  logic [2*bit_width-1:0] rsel;
  logic                   release_frame, wr_free, accept, close;

  assign release_frame = (state == STREAM) && valid_o && ready_i && last_o;
  // A bank being released this cycle already counts as free for the writer.
  assign wr_free = !full[wbank] || (release_frame && (rbank == wbank));
  assign accept  = valid_i && wr_free;
  assign close   = accept && (wcnt == LAST_CNT);
  assign rsel    = rdata[rbank];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign we[b]       = accept && (wbank == 1'(b));
    assign set_full[b] = close && (wbank == 1'(b));
    assign clr_full[b] = release_frame && (rbank == 1'(b));

    fft_frame_bank #(.bit_width(bit_width), .N(N), .SIZE(SIZE)) u_bank (
      .clk      (clk),
      .rst      (rst),
      .we       (we[b]),
      .waddr    (wr_ptr_i),
      .wdata    ({Re_i, Im_i}),
      .raddr    (rcnt[SIZE-1:0]),
      .rdata    (rdata[b]),
      .set_full (set_full[b]),
      .clr_full (clr_full[b]),
      .full     (full[b])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbank      <= 1'b0;
      wcnt       <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (valid_i && !wr_free) overflow_o <= 1'b1;
      if (accept) begin
        if (close) begin
          wcnt  <= '0;
          wbank <= ~wbank;
        end else begin
          wcnt <= wcnt + (SIZE+1)'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rbank        <= 1'b0;
      rcnt         <= '0;
      valid_o      <= 1'b0;
      Re_o         <= '0;
      Im_o         <= '0;
      idx_o        <= '0;
      last_o       <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (full[rbank]) begin
            state <= STREAM;
            rcnt  <= '0;
          end
        end
        STREAM: begin
          if (release_frame) begin
            valid_o      <= 1'b0;
            last_o       <= 1'b0;
            rbank        <= ~rbank;
            frame_done_o <= 1'b1;
            state        <= IDLE;
          end else if ((!valid_o || ready_i) && (rcnt < FRAME_CNT)) begin
            valid_o <= 1'b1;
            Re_o    <= rsel[2*bit_width-1:bit_width];
            Im_o    <= rsel[bit_width-1:0];
            idx_o   <= rcnt[SIZE-1:0];
            last_o  <= (rcnt == LAST_CNT);
            rcnt    <= rcnt + (SIZE+1)'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_output_reader.sv
// Bench for fft_output_reader: frame-level reference model feeding an expected queue,
// with an independent monitor that checks every handshake, stall hold and done pulse.
module tb_fft_output_reader;
  import fft_pkg::*;

  localparam int BW   = 24;
  localparam int N    = 16;
  localparam int SIZE = 4;
  localparam int EW   = 1 + SIZE + 2*BW;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 valid_i = 1'b0;
  logic                 ready_i = 1'b0;
  logic signed [BW-1:0] Re_i = '0;
  logic signed [BW-1:0] Im_i = '0;
  logic [SIZE-1:0]      wr_ptr_i = '0;
  logic                 valid_o, last_o, frame_done_o, overflow_o;
  logic signed [BW-1:0] Re_o, Im_o;
  logic [SIZE-1:0]      idx_o;

  int checks = 0;
  int passes = 0;
  logic [EW-1:0] exp_q[$];

  // Reference model: a frame is N accepted beats scattered by pointer; at most two
  // completed, unconsumed frames can be held, beyond which beats are dropped.
  logic signed [BW-1:0] m_re [N];
  logic signed [BW-1:0] m_im [N];
  int  m_cnt   = 0;
  int  occ     = 0;
  bit  exp_ovf = 1'b0;
  bit  rand_ready = 1'b0;

  fft_output_reader #(.bit_width(BW), .N(N), .SIZE(SIZE)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .Re_i         (Re_i),
    .Im_i         (Im_i),
    .wr_ptr_i     (wr_ptr_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .Re_o         (Re_o),
    .Im_o         (Im_o),
    .idx_o        (idx_o),
    .last_o       (last_o),
    .frame_done_o (frame_done_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  function automatic logic [SIZE-1:0] bitrev(input logic [SIZE-1:0] v);
    logic [SIZE-1:0] r;
    for (int i = 0; i < SIZE; i++) r[i] = v[SIZE-1-i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one beat; the model decides accept/drop just before the capturing edge.
  task automatic write_beat(input logic [SIZE-1:0] p, input logic signed [BW-1:0] re,
                            input logic signed [BW-1:0] im);
    valid_i  = 1'b1;
    wr_ptr_i = p;
    Re_i     = re;
    Im_i     = im;
    #5;
    if (occ >= 2) begin
      exp_ovf = 1'b1;
    end else begin
      m_re[p] = re;
      m_im[p] = im;
      m_cnt++;
      if (m_cnt == N) begin
        for (int i = 0; i < N; i++)
          exp_q.push_back({1'(i == N-1), SIZE'(i), m_re[i], m_im[i]});
        occ++;
        m_cnt = 0;
      end
    end
    tick();
    valid_i = 1'b0;
  endtask

  task automatic write_frame(input bit bitrev_mode, input bit gaps);
    int perm [N];
    int j, t;
    for (int i = 0; i < N; i++) perm[i] = i;
    for (int i = N-1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int k = 0; k < N; k++) begin
      if (bitrev_mode) write_beat(bitrev(SIZE'(k)), BW'(k), -BW'(k));
      else             write_beat(SIZE'(perm[k]), BW'($urandom), BW'($urandom));
      if (gaps) repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      tick();
      t++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d beats outstanding, expected 0", exp_q.size());
      exp_q.delete();
      occ = 0;
    end
    repeat (3) tick();
  endtask

  task automatic wait_room();
    int t = 0;
    while (occ >= 2 && t < 3000) begin
      tick();
      t++;
    end
    if (occ >= 2) begin
      checks++;
      $display("FAIL room: buffer still holds %0d frames, expected < 2", occ);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    exp_q.delete();
    occ = 0;
    m_cnt = 0;
    exp_ovf = 1'b0;
  endtask

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      ready_i = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: pops on each handshake, checks holding during stalls and the done pulse.
  logic [EW-1:0] held;
  logic [EW-1:0] e;
  bit hold_pending = 1'b0;
  bit done_pending = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      hold_pending = 1'b0;
      done_pending = 1'b0;
    end else begin
      if (done_pending || frame_done_o)
        check("frame_done", 64'(frame_done_o), 64'(done_pending));
      done_pending = 1'b0;
      if (hold_pending) begin
        check("hold_valid", 64'(valid_o), 64'(1'b1));
        check("hold_data", 64'({last_o, idx_o, Re_o, Im_o}), 64'(held));
      end
      hold_pending = 1'b0;
      if (valid_o) begin
        if (ready_i) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL beat: unexpected beat idx %0d, expected none", idx_o);
          end else begin
            e = exp_q.pop_front();
            check("beat", 64'({last_o, idx_o, Re_o, Im_o}), 64'(e));
            if (e[EW-1]) begin
              done_pending = 1'b1;
              occ--;
            end
          end
        end else begin
          hold_pending = 1'b1;
          held = {last_o, idx_o, Re_o, Im_o};
        end
      end
    end
  end

  initial begin
    bit bad;
    int t;

    // Reset then idle
    repeat (2) tick();
    rst = 1'b0;
    check("rst_valid", 64'(valid_o), 64'(1'b0));
    check("rst_re", 64'(Re_o), 64'(0));
    check("rst_im", 64'(Im_o), 64'(0));
    check("rst_idx", 64'(idx_o), 64'(0));
    check("rst_last", 64'(last_o), 64'(1'b0));
    check("rst_done", 64'(frame_done_o), 64'(1'b0));
    check("rst_ovf", 64'(overflow_o), 64'(1'b0));
    bad = 1'b0;
    repeat (50) begin
      tick();
      if (valid_o !== 1'b0 || Re_o !== '0 || Im_o !== '0 || idx_o !== '0 ||
          last_o !== 1'b0 || frame_done_o !== 1'b0 || overflow_o !== 1'b0) bad = 1'b1;
    end
    check("idle_quiet", 64'(bad), 64'(1'b0));

    // Bit-reversed frame with latency check
    ready_i = 1'b1;
    write_frame(1'b1, 1'b0);
    check("lat_e0", 64'(valid_o), 64'(1'b0));
    tick();
    check("lat_e1", 64'(valid_o), 64'(1'b0));
    tick();
    check("lat_e2", 64'(valid_o), 64'(1'b1));
    check("lat_idx", 64'(idx_o), 64'(0));
    wait_drain();

    // Random backpressure and input gaps
    rand_ready = 1'b1;
    for (int f = 0; f < 4; f++) begin
      wait_room();
      write_frame(1'b0, 1'b1);
    end
    wait_drain();
    rand_ready = 1'b0;
    tick();
    ready_i = 1'b1;

    // Ping-pong overlap under full stall
    ready_i = 1'b0;
    write_frame(1'b0, 1'b0);
    write_frame(1'b0, 1'b0);
    repeat (3) tick();
    check("pp_ovf", 64'(overflow_o), 64'(exp_ovf));
    check("pp_valid", 64'(valid_o), 64'(1'b1));
    ready_i = 1'b1;
    wait_drain();

    // Overflow: third frame while two are held
    ready_i = 1'b0;
    write_frame(1'b0, 1'b0);
    write_frame(1'b0, 1'b0);
    check("ovf_before", 64'(overflow_o), 64'(exp_ovf));
    write_beat(SIZE'(3), BW'(123), BW'(-456));
    check("ovf_first", 64'(overflow_o), 64'(exp_ovf));
    for (int k = 1; k < N; k++) write_beat(SIZE'(k), BW'($urandom), BW'($urandom));
    ready_i = 1'b1;
    wait_drain();
    check("ovf_sticky", 64'(overflow_o), 64'(exp_ovf));
    do_reset();
    check("ovf_cleared", 64'(overflow_o), 64'(exp_ovf));

    // Reset mid-stream at idx 7
    ready_i = 1'b1;
    write_frame(1'b0, 1'b0);
    t = 0;
    while (!(valid_o && idx_o == SIZE'(7)) && t < 200) begin
      tick();
      t++;
    end
    if (t >= 200) begin
      checks++;
      $display("FAIL midrst_wait: idx 7 never presented, expected within 200 cycles");
    end
    rst = 1'b1;
    tick();
    check("midrst_valid", 64'(valid_o), 64'(1'b0));
    rst = 1'b0;
    exp_q.delete();
    occ = 0;
    m_cnt = 0;
    write_frame(1'b1, 1'b0);
    wait_drain();
    write_frame(1'b0, 1'b0);
    wait_drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
